// File: rtl/register_file_pkg.sv
// Shared types and constants for the architectural register file and its neighbours.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: register/ROB index widths, the zero-register index, the ROB-index
// type shared with the reorder buffer and instruction unit, and the packed
// commit record fed to the read-port bypass.
package register_file_pkg;

    localparam int ROB_WIDTH     = 4;
    localparam int REG_IDX_WIDTH = 5;
    localparam int REG_COUNT     = 1 << REG_IDX_WIDTH;
    localparam int DATA_WIDTH    = 32;

    typedef logic [ROB_WIDTH-1:0]     robIdT;
    typedef logic [REG_IDX_WIDTH-1:0] regIdxT;
    typedef logic [DATA_WIDTH-1:0]    regDataT;

    // x0 is hard-wired to zero: never renamed, never written.
    localparam regIdxT ZERO_REG = '0;

    // One commit from the reorder buffer, bundled for the bypass path.
    typedef struct packed {
        logic    valid;
        regIdxT  dest;
        robIdT   robId;
        regDataT value;
    } commitT;

    // True for any register that can actually hold state.
    function automatic logic isArchDest(input regIdxT idx);
        return idx != ZERO_REG;
    endfunction

endpackage

// File: rtl/register_file_if.sv
// Bus between the register file and its producers/consumers (ROB commit, rename, operand reads).
// Latency: n/a (wiring only); read results are combinational in the same cycle.
// Backpressure: none; every strobe is accepted unconditionally.
//
// master: reorder buffer + instruction unit side (drives clear/commit/rename/read indices).
// slave : register file side (returns busy/dep/value per source operand).
interface register_file_if;
    import register_file_pkg::*;

    // flush and commit from the reorder buffer
    logic    clear;
    logic    regUpdateValid;
    regIdxT  regUpdateDest;
    regDataT regValue;
    robIdT   regUpdateRobId;

    // rename from the instruction unit
    logic    renameValid;
    regIdxT  renameDest;
    robIdT   renameRobId;

    // source operand lookups
    regIdxT  rs1Index;
    logic    rs1Busy;
    robIdT   rs1Dep;
    regDataT rs1Value;
    regIdxT  rs2Index;
    logic    rs2Busy;
    robIdT   rs2Dep;
    regDataT rs2Value;

    modport master (
        output clear, regUpdateValid, regUpdateDest, regValue, regUpdateRobId,
        output renameValid, renameDest, renameRobId,
        output rs1Index, rs2Index,
        input  rs1Busy, rs1Dep, rs1Value,
        input  rs2Busy, rs2Dep, rs2Value
    );

    modport slave (
        input  clear, regUpdateValid, regUpdateDest, regValue, regUpdateRobId,
        input  renameValid, renameDest, renameRobId,
        input  rs1Index, rs2Index,
        output rs1Busy, rs1Dep, rs1Value,
        output rs2Busy, rs2Dep, rs2Value
    );

endinterface

// File: rtl/register_file_read_port.sv
// One source-operand lookup: resolves x0, committed value, same-cycle commit bypass or ROB dependency.
// Latency: combinational, zero cycles.
// Backpressure: none.
//
// Ports: index (register read), entryBusy/entryTag/entryValue (stored state of
// that register), commit (same-cycle ROB commit), busy/dep/value (result).
module register_file_read_port
    import register_file_pkg::*;
(
    input  regIdxT  index,
    input  logic    entryBusy,
    input  robIdT   entryTag,
    input  regDataT entryValue,
    input  commitT  commit,
    output logic    busy,
    output robIdT   dep,
    output regDataT value
);

    // The bypass only fires when the committing entry is exactly the producer
    // this register is waiting on; an older commit to the same register must
    // not satisfy a reader that depends on a newer rename.
    logic bypassHit;

    always_comb begin
        bypassHit = commit.valid
                 && (commit.dest == index)
                 && (commit.robId == entryTag);
    end

    always_comb begin
        busy  = 1'b0;
        dep   = '0;
        value = '0;
        if (index == ZERO_REG) begin
            // x0 reads as a ready zero regardless of any stray state
        end else if (!entryBusy) begin
            value = entryValue;
        end else if (bypassHit) begin
            value = commit.value;
        end else begin
            busy = 1'b1;
            dep  = entryTag;
        end
    end

endmodule

// File: rtl/register_file.sv
// Architectural register file (32 x 32b) with per-register busy bit and ROB rename tag.
// Latency: reads combinational (zero cycles); commit/rename/clear take effect at the next clockIn edge.
// Backpressure: none; one commit and one rename accepted every cycle.
//
// Ports: clockIn (rising-edge clock), resetIn (synchronous, active high),
// bus (register_file_if.slave: clear, commit, rename, two read ports).
module register_file
    import register_file_pkg::*;
(
    input  logic           clockIn,
    input  logic           resetIn,
    register_file_if.slave bus
);

    regDataT              valueMem [REG_COUNT];
    robIdT                tagMem   [REG_COUNT];
    logic [REG_COUNT-1:0] busyMem;

    // Per-register decode of this cycle's commit and rename.
    logic [REG_COUNT-1:0] commitHit;
    logic [REG_COUNT-1:0] renameHit;

    always_comb begin
        commitHit = '0;
        renameHit = '0;
        if (bus.regUpdateValid && isArchDest(bus.regUpdateDest)) begin
            commitHit[bus.regUpdateDest] = 1'b1;
        end
        // a flush squashes the rename issued in the same cycle
        if (bus.renameValid && !bus.clear && isArchDest(bus.renameDest)) begin
            renameHit[bus.renameDest] = 1'b1;
        end
    end

    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            busyMem <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                valueMem[i] <= '0;
                tagMem[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                // Commits are older than anything being flushed, so the
                // value lands even under clear.
                if (commitHit[i]) begin
                    valueMem[i] <= bus.regValue;
                end

                // Busy/tag priority: flush, then rename, then matching commit.
                // A commit whose ROB id differs from the current tag belongs to
                // an older rename and must leave the newer dependency intact.
                if (bus.clear) begin
                    busyMem[i] <= 1'b0;
                end else if (renameHit[i]) begin
                    busyMem[i] <= 1'b1;
                    tagMem[i]  <= bus.renameRobId;
                end else if (commitHit[i] && busyMem[i]
                             && (tagMem[i] == bus.regUpdateRobId)) begin
                    busyMem[i] <= 1'b0;
                end
            end
        end
    end

    commitT commitBus;

    always_comb begin
        commitBus.valid = bus.regUpdateValid;
        commitBus.dest  = bus.regUpdateDest;
        commitBus.robId = bus.regUpdateRobId;
        commitBus.value = bus.regValue;
    end

    // Reads see state before this cycle's rename, so an instruction's sources
    // never depend on its own destination.
    register_file_read_port rs1Port (
        .index      (bus.rs1Index),
        .entryBusy  (busyMem[bus.rs1Index]),
        .entryTag   (tagMem[bus.rs1Index]),
        .entryValue (valueMem[bus.rs1Index]),
        .commit     (commitBus),
        .busy       (bus.rs1Busy),
        .dep        (bus.rs1Dep),
        .value      (bus.rs1Value)
    );

    register_file_read_port rs2Port (
        .index      (bus.rs2Index),
        .entryBusy  (busyMem[bus.rs2Index]),
        .entryTag   (tagMem[bus.rs2Index]),
        .entryValue (valueMem[bus.rs2Index]),
        .commit     (commitBus),
        .busy       (bus.rs2Busy),
        .dep        (bus.rs2Dep),
        .value      (bus.rs2Value)
    );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed vector table, reset-override sequence, randomized model check.
// Latency: reads checked combinationally in the same cycle the inputs are driven.
// Backpressure: n/a.
module tb_register_file;
    import register_file_pkg::*;

    typedef struct {
        logic    clr;
        logic    cv;  regIdxT cd; robIdT cr; regDataT cval;
        logic    rv;  regIdxT rd; robIdT rr;
        regIdxT  i1;  logic e1b; robIdT e1d; regDataT e1v;
        regIdxT  i2;  logic e2b; robIdT e2d; regDataT e2v;
    } vecT;

    localparam int NUM_ROWS = 26;
    localparam int NUM_RAND = 600;

    logic clockIn = 1'b0;
    logic resetIn;
    always #5 clockIn = ~clockIn;

    register_file_if bus();

    register_file dut (
        .clockIn (clockIn),
        .resetIn (resetIn),
        .bus     (bus)
    );

    int nVec = 0;
    int nMis = 0;

    // Reference state: what each architectural register holds per the rules.
    regDataT mVal  [REG_COUNT];
    logic    mBusy [REG_COUNT];
    robIdT   mTag  [REG_COUNT];

    function automatic vecT mk(
        input logic clr, input logic cv, input regIdxT cd, input robIdT cr, input regDataT cval,
        input logic rv, input regIdxT rd, input robIdT rr,
        input regIdxT i1, input logic e1b, input robIdT e1d, input regDataT e1v,
        input regIdxT i2, input logic e2b, input robIdT e2d, input regDataT e2v);
        vecT v;
        v.clr = clr; v.cv = cv; v.cd = cd; v.cr = cr; v.cval = cval;
        v.rv = rv; v.rd = rd; v.rr = rr;
        v.i1 = i1; v.e1b = e1b; v.e1d = e1d; v.e1v = e1v;
        v.i2 = i2; v.e2b = e2b; v.e2d = e2d; v.e2v = e2v;
        return v;
    endfunction

    task automatic drive(input logic clr, input logic cv, input regIdxT cd, input robIdT cr,
                         input regDataT cval, input logic rv, input regIdxT rd, input robIdT rr,
                         input regIdxT i1, input regIdxT i2);
        bus.clear          = clr;
        bus.regUpdateValid = cv;
        bus.regUpdateDest  = cd;
        bus.regUpdateRobId = cr;
        bus.regValue       = cval;
        bus.renameValid    = rv;
        bus.renameDest     = rd;
        bus.renameRobId    = rr;
        bus.rs1Index       = i1;
        bus.rs2Index       = i2;
    endtask

    // dep is only meaningful while busy (and is defined as 0 for x0); value only while not busy.
    task automatic checkPort(input string name, input regIdxT idx,
                             input logic eb, input robIdT ed, input regDataT ev,
                             input logic ab, input robIdT ad, input regDataT av);
        logic ok;
        nVec++;
        ok = (ab == eb);
        if (eb || idx == ZERO_REG) ok = ok && (ad == ed);
        if (!eb) ok = ok && (av == ev);
        if (!ok) begin
            nMis++;
            $display("FAIL %s x%0d: got busy=%0b dep=%0d value=%h, expected busy=%0b dep=%0d value=%h",
                     name, idx, ab, ad, av, eb, ed, ev);
        end
    endtask

    task automatic checkDep(input string name, input robIdT act, input robIdT exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got dep=%0d, expected dep=%0d", name, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < REG_COUNT; i++) begin
            mVal[i] = '0; mBusy[i] = 1'b0; mTag[i] = '0;
        end
    endtask

    // Read result from the architectural rules using pre-edge state.
    task automatic modelRead(input regIdxT idx, input logic cv, input regIdxT cd, input robIdT cr,
                             input regDataT cval, output logic b, output robIdT d, output regDataT v);
        b = 1'b0; d = '0; v = '0;
        if (idx == 0) return;
        if (!mBusy[idx]) begin
            v = mVal[idx];
        end else if (cv && cd == idx && cr == mTag[idx]) begin
            v = cval;
        end else begin
            b = 1'b1; d = mTag[idx];
        end
    endtask

    task automatic modelUpdate(input logic clr, input logic cv, input regIdxT cd, input robIdT cr,
                               input regDataT cval, input logic rv, input regIdxT rd, input robIdT rr);
        if (cv && cd != 0) begin
            mVal[cd] = cval;
            if (mBusy[cd] && mTag[cd] == cr) mBusy[cd] = 1'b0;
        end
        if (rv && rd != 0 && !clr) begin
            mBusy[rd] = 1'b1;
            mTag[rd]  = rr;
        end
        if (clr) for (int i = 0; i < REG_COUNT; i++) mBusy[i] = 1'b0;
    endtask

    vecT tbl [NUM_ROWS];

    initial begin
        logic    clr, cv, rv, rst, eb1, eb2;
        regIdxT  cd, rd, i1, i2;
        robIdT   cr, rr, ed1, ed2;
        regDataT cval, ev1, ev2;

        //          clr cv cd cr cval          rv rd rr  i1 b d v             i2 b d v
        tbl[0]  = mk(0, 0, 0, 0, 0,            0, 0, 0,  5, 0, 0, 0,          0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0,            1, 5, 3,  5, 0, 0, 0,          5, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0,            0, 0, 0,  5, 1, 3, 0,          0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 5, 3, 32'hDEADBEEF, 0, 0, 0,  5, 0, 0, 32'hDEADBEEF, 5, 0, 0, 32'hDEADBEEF);
        tbl[4]  = mk(0, 0, 0, 0, 0,            0, 0, 0,  5, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0,            1, 7, 2,  7, 0, 0, 0,          5, 0, 0, 32'hDEADBEEF);
        tbl[6]  = mk(0, 0, 0, 0, 0,            1, 7, 9,  7, 1, 2, 0,          0, 0, 0, 0);
        tbl[7]  = mk(0, 1, 7, 2, 32'h11,       0, 0, 0,  7, 1, 9, 0,          5, 0, 0, 32'hDEADBEEF);
        tbl[8]  = mk(0, 0, 0, 0, 0,            0, 0, 0,  7, 1, 9, 0,          0, 0, 0, 0);
        tbl[9]  = mk(0, 1, 7, 9, 32'h22,       0, 0, 0,  7, 0, 0, 32'h22,     7, 0, 0, 32'h22);
        tbl[10] = mk(0, 0, 0, 0, 0,            0, 0, 0,  7, 0, 0, 32'h22,     5, 0, 0, 32'hDEADBEEF);
        tbl[11] = mk(0, 1, 4, 1, 32'h55,       1, 4, 6,  4, 0, 0, 0,          0, 0, 0, 0);
        tbl[12] = mk(0, 0, 0, 0, 0,            0, 0, 0,  4, 1, 6, 0,          7, 0, 0, 32'h22);
        tbl[13] = mk(0, 1, 4, 6, 32'h66,       0, 0, 0,  4, 0, 0, 32'h66,     4, 0, 0, 32'h66);
        tbl[14] = mk(0, 0, 0, 0, 0,            0, 0, 0,  4, 0, 0, 32'h66,     0, 0, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 0,            1, 1, 1,  1, 0, 0, 0,          2, 0, 0, 0);
        tbl[16] = mk(0, 0, 0, 0, 0,            1, 2, 2,  1, 1, 1, 0,          2, 0, 0, 0);
        tbl[17] = mk(0, 0, 0, 0, 0,            1, 3, 3,  2, 1, 2, 0,          1, 1, 1, 0);
        tbl[18] = mk(1, 1, 1, 1, 32'hAA,       1, 8, 4,  3, 1, 3, 0,          1, 0, 0, 32'hAA);
        tbl[19] = mk(0, 0, 0, 0, 0,            0, 0, 0,  1, 0, 0, 32'hAA,     2, 0, 0, 0);
        tbl[20] = mk(0, 0, 0, 0, 0,            0, 0, 0,  3, 0, 0, 0,          8, 0, 0, 0);
        tbl[21] = mk(0, 1, 0, 5, 32'h1234,     1, 0, 5,  0, 0, 0, 0,          0, 0, 0, 0);
        tbl[22] = mk(0, 0, 0, 0, 0,            0, 0, 0,  0, 0, 0, 0,          8, 0, 0, 0);
        tbl[23] = mk(0, 0, 0, 0, 0,            1, 9, 15, 9, 0, 0, 0,          4, 0, 0, 32'h66);
        tbl[24] = mk(0, 1, 9, 15, 32'h99,      0, 0, 0,  9, 0, 0, 32'h99,     9, 0, 0, 32'h99);
        tbl[25] = mk(0, 0, 0, 0, 0,            0, 0, 0,  9, 0, 0, 32'h99,     3, 0, 0, 0);

        // Reset held with a rename and commit pending: reset must win.
        resetIn = 1'b1;
        drive(1'b0, 1'b1, 5'd6, 4'd2, 32'hCAFE, 1'b1, 5'd6, 4'd2, 5'd0, 5'd0);
        repeat (2) @(posedge clockIn);
        @(negedge clockIn);
        resetIn = 1'b0;
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0, 5'd6, 5'd0);
        #1;
        checkPort("reset.rs1", 5'd6, 1'b0, '0, '0, bus.rs1Busy, bus.rs1Dep, bus.rs1Value);
        checkPort("reset.rs2", 5'd0, 1'b0, '0, '0, bus.rs2Busy, bus.rs2Dep, bus.rs2Value);
        checkDep("reset.rs1dep", bus.rs1Dep, '0);

        for (int r = 0; r < NUM_ROWS; r++) begin
            @(negedge clockIn);
            drive(tbl[r].clr, tbl[r].cv, tbl[r].cd, tbl[r].cr, tbl[r].cval,
                  tbl[r].rv, tbl[r].rd, tbl[r].rr, tbl[r].i1, tbl[r].i2);
            #1;
            checkPort($sformatf("row%0d.rs1", r), tbl[r].i1, tbl[r].e1b, tbl[r].e1d, tbl[r].e1v,
                      bus.rs1Busy, bus.rs1Dep, bus.rs1Value);
            checkPort($sformatf("row%0d.rs2", r), tbl[r].i2, tbl[r].e2b, tbl[r].e2d, tbl[r].e2v,
                      bus.rs2Busy, bus.rs2Dep, bus.rs2Value);
        end

        // Mid-run reset with same-cycle rename/commit/clear must wipe everything.
        @(negedge clockIn);
        resetIn = 1'b1;
        drive(1'b1, 1'b1, 5'd9, 4'd7, 32'h77, 1'b1, 5'd9, 4'd7, 5'd0, 5'd0);
        @(negedge clockIn);
        resetIn = 1'b0;
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0, 5'd9, 5'd5);
        #1;
        checkPort("midreset.rs1", 5'd9, 1'b0, '0, '0, bus.rs1Busy, bus.rs1Dep, bus.rs1Value);
        checkPort("midreset.rs2", 5'd5, 1'b0, '0, '0, bus.rs2Busy, bus.rs2Dep, bus.rs2Value);
        checkDep("midreset.rs2dep", bus.rs2Dep, '0);

        // Randomized traffic against the reference model, starting from reset state.
        modelReset();
        for (int n = 0; n < NUM_RAND; n++) begin
            @(negedge clockIn);
            rst  = ($urandom_range(0, 59) == 0);
            clr  = ($urandom_range(0, 19) == 0);
            cv   = ($urandom_range(0, 1) == 1);
            cd   = regIdxT'($urandom_range(0, 7));
            cr   = robIdT'($urandom_range(0, 3));
            cval = $urandom();
            rv   = ($urandom_range(0, 1) == 1);
            rd   = regIdxT'($urandom_range(0, 7));
            rr   = robIdT'($urandom_range(0, 3));
            i1   = regIdxT'($urandom_range(0, 7));
            i2   = regIdxT'($urandom_range(0, 7));
            resetIn = rst;
            drive(clr, cv, cd, cr, cval, rv, rd, rr, i1, i2);
            #1;
            modelRead(i1, cv, cd, cr, cval, eb1, ed1, ev1);
            modelRead(i2, cv, cd, cr, cval, eb2, ed2, ev2);
            checkPort($sformatf("rand%0d.rs1", n), i1, eb1, ed1, ev1, bus.rs1Busy, bus.rs1Dep, bus.rs1Value);
            checkPort($sformatf("rand%0d.rs2", n), i2, eb2, ed2, ev2, bus.rs2Busy, bus.rs2Dep, bus.rs2Value);
            if (rst) modelReset();
            else     modelUpdate(clr, cv, cd, cr, cval, rv, rd, rr);
        end

        @(negedge clockIn);
        resetIn = 1'b0;
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0, '0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Architectural register file with rename tags; sits directly downstream of the reorder buffer's commit port.
- Holds 32 x 32-bit values plus a per-register busy bit and ROB tag.
- Accepts one rename per cycle from the instruction unit and one commit per cycle from the reorder buffer.
- Tells the instruction unit, per source operand, either the committed value or the ROB index it depends on.

Parameters:
- ROB_WIDTH, 4, width of a reorder buffer index.
- REG_COUNT, 32, number of architectural registers (fixed at 32, index width 5).

Ports:
- clockIn  input  1  clock; all state updates on the rising edge.
- resetIn  input  1  synchronous, active-high reset.
- clear  input  1  misprediction flush from the reorder buffer.
- regUpdateValid  input  1  commit strobe from the reorder buffer.
- regUpdateDest  input  5  committed destination register.
- regValue  input  32  committed value.
- regUpdateRobId  input  ROB_WIDTH  ROB index of the committing entry.
- renameValid  input  1  instruction unit issues an instruction with a destination register.
- renameDest  input  5  destination register of the issued instruction.
- renameRobId  input  ROB_WIDTH  ROB index allocated to that instruction.
- rs1Index  input  5  source register 1.
- rs1Busy  output  1  rs1 awaits an in-flight ROB entry.
- rs1Dep  output  ROB_WIDTH  ROB index producing rs1 (meaningful only when rs1Busy=1).
- rs1Value  output  32  rs1 value (meaningful only when rs1Busy=0).
- rs2Index  input  5  source register 2.
- rs2Busy  output  1  same as rs1Busy, for rs2.
- rs2Dep  output  ROB_WIDTH  same as rs1Dep, for rs2.
- rs2Value  output  32  same as rs1Value, for rs2.

Behaviour:
- Reset (resetIn=1 at a posedge): all values are 0, all busy bits 0, all tags 0. Read outputs are then busy=0, value=0, dep=0. Reset overrides clear, commit and rename in the same cycle.
- Read ports are combinational, zero latency, and apply in this order:
  - index 0: busy=0, value=0, dep=0.
  - register not busy: busy=0, value=stored value.
  - busy, with a same-cycle commit where dest==index and robId==tag: busy=0, value=regValue (commit bypass).
  - otherwise: busy=1, dep=tag.
- Read ports never forward the same-cycle rename; the sources of an instruction are read before its own rename takes effect.
- Commit (regUpdateValid=1, dest!=0), at the posedge:
  - the value is always written.
  - the busy bit clears only if busy and tag==regUpdateRobId; an older commit must not clear a newer rename.
- Commit to x0 is ignored.
- Rename (renameValid=1, dest!=0, clear=0), at the posedge: busy<=1, tag<=renameRobId. Rename to x0 is ignored.
- Rename and commit to the same register in one cycle: the value is written, busy stays 1, and the tag becomes renameRobId. The rename always wins busy and tag.
- Clear=1 at a posedge:
  - all busy bits become 0.
  - a commit in the same cycle still writes its value; it is older than the mispredicted branch.
  - a rename in the same cycle is dropped.
- ROB index wrap-around needs no special handling: tags are compared for equality only.

Decomposition:
- Shared package holds:
  - ROB_WIDTH and REG_COUNT constants.
  - REG_IDX_WIDTH=5.
  - The zero-register index constant.
  - The ROB-index typedef, shared with the reorder buffer and the instruction unit.
- One natural sub-module, register_file_read_port, instantiated twice. It is purely combinational and contains the x0 / busy / commit-bypass priority mux.
- Storage and update logic stay in register_file.

Test Plan:
- Reset, then read rs1=5, rs2=0 -> busy=0, value=0 on both.
- Rename x5 robId 3; next cycle read rs1=5 -> busy=1, dep=3. Commit x5 robId 3 value 0xDEADBEEF; same cycle read rs1=5 -> busy=0, value 0xDEADBEEF via bypass. Next cycle -> stored, busy=0.
- Stale commit: rename x7 robId 2, then rename x7 robId 9. Commit x7 robId 2 value 0x11 -> x7 value=0x11, still busy, dep=9. Commit robId 9 value 0x22 -> busy=0, value=0x22.
- Same-cycle rename x4 robId 6 and commit x4 (tag 1, value 0x55) -> next cycle busy=1, dep=6; a later read after commit robId 6 returns the new value.
- Rename x1, x2, x3 (robIds 1, 2, 3), then clear together with commit x1 robId 1 value 0xAA and rename x8 robId 4 -> next cycle all busy=0, x1=0xAA, x8 not busy.
- x0 handling: rename x0 robId 5 and commit x0 value 0x1234 -> read x0 gives busy=0, value=0.
